i2c_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single I2C master interface between three on-chip requesters (0: ball-transfer, 1: score update, 2: game-event/status). It latches the winning requester's 24-bit payload, issues one start pulse to the I2C master, waits for its completion or a watchdog timeout, and reports completion back to the requester. It sits between the game-side controllers and the I2C interface, on the 25 MHz game clock.

---
 rtl/i2c_req_arbiter_if.sv | 37 +++
 rtl/i2c_req_arbiter.sv | 122 ++++++++++++
 tb/tb_i2c_req_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_if.sv
// Handshake bundle between the game-side requesters, the arbiter
// and the shared I2C master.
interface i2c_req_arbiter_if;
   logic [2:0]  req;
   logic [71:0] req_payload;
   logic [2:0]  grant;
   logic [2:0]  done;
   logic [2:0]  err;
   logic        m_start;
   logic [23:0] m_data;
   logic        m_done;
   logic        busy;

   modport master (
      input  req,
      input  req_payload,
      input  m_done,
      output grant,
      output done,
      output err,
      output m_start,
      output m_data,
      output busy
   );

   modport slave (
      output req,
      output req_payload,
      output m_done,
      input  grant,
      input  done,
      input  err,
      input  m_start,
      input  m_data,
      input  busy
   );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between three requesters,
// with a saturating watchdog on each outstanding transaction.
module i2c_req_arbiter #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input logic               clk,
   input logic               reset,
   i2c_req_arbiter_if.master bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE
   } state_t;

   state_t        r_state;
   logic [1:0]    r_last;
   logic [2:0]    r_win;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_grant;
   logic [2:0]    r_done;
   logic [2:0]    r_err;
   logic          r_m_start;
   logic [23:0]   r_m_data;
   logic          r_busy;

   logic [1:0]    w_p1;
   logic [1:0]    w_p2;
   logic [1:0]    w_sel;
   logic [2:0]    w_oh;
   logic [23:0]   w_pay;
   logic          w_any;
   logic          w_pulse;

   // Search order starts just after the last winner and wraps.
   always_comb begin
      w_p1 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
      w_p2 = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
      w_any = |bus.req;
      w_sel = r_last;
      if (bus.req[w_p1])
         w_sel = w_p1;
      else if (bus.req[w_p2])
         w_sel = w_p2;
      w_oh = 3'b001 << w_sel;
      w_pay = bus.req_payload[23:0];
      case (w_sel)
         2'd1:    w_pay = bus.req_payload[47:24];
         2'd2:    w_pay = bus.req_payload[71:48];
         default: w_pay = bus.req_payload[23:0];
      endcase
   end

   // Hold off arbitration while done/err is still pulsing.
   assign w_pulse = (|r_done) | (|r_err);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_last    <= 2'd2;
         r_win     <= 3'b000;
         r_cnt     <= '0;
         r_grant   <= 3'b000;
         r_done    <= 3'b000;
         r_err     <= 3'b000;
         r_m_start <= 1'b0;
         r_m_data  <= 24'h0;
         r_busy    <= 1'b0;
      end else begin
         r_grant   <= 3'b000;
         r_done    <= 3'b000;
         r_err     <= 3'b000;
         r_m_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any && !w_pulse) begin
                  r_win     <= w_oh;
                  r_last    <= w_sel;
                  r_m_data  <= w_pay;
                  r_grant   <= w_oh;
                  r_m_start <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.m_done) begin
                  r_done  <= r_win;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_cnt == LAST_CNT) begin
                  r_err   <= r_win;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant   = r_grant;
   assign bus.done    = r_done;
   assign bus.err     = r_err;
   assign bus.m_start = r_m_start;
   assign bus.m_data  = r_m_data;
   assign bus.busy    = r_busy;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a transaction table plus
// hand-written reset and busy-isolation sequences.
module tb_i2c_req_arbiter;

   localparam int TO = 16;
   localparam logic [71:0] P = {24'hC0FFEE, 24'hA51234, 24'h0BA11A};
   localparam logic [71:0] Q = {24'h777777, 24'h654321, 24'h123456};

   logic clk;
   logic reset;
   int   errs;
   int   checks;

   i2c_req_arbiter_if bus ();

   i2c_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      logic [2:0]  req;
      logic [71:0] pay;
      int          dly;
      logic [2:0]  g;
      logic [23:0] d;
      logic [2:0]  dn;
      logic [2:0]  er;
   } vec_t;

   vec_t tv[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [71:0] act,
                      input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   int   n;
   logic stray;

   initial begin
      errs   = 0;
      checks = 0;
      // req, payload, m_done delay (-1 = never), grant, m_data, done, err
      tv[0] = '{3'b111, P,  1, 3'b001, 24'h0BA11A, 3'b001, 3'b000};
      tv[1] = '{3'b111, P,  1, 3'b010, 24'hA51234, 3'b010, 3'b000};
      tv[2] = '{3'b111, P,  1, 3'b100, 24'hC0FFEE, 3'b100, 3'b000};
      tv[3] = '{3'b111, P,  1, 3'b001, 24'h0BA11A, 3'b001, 3'b000};
      tv[4] = '{3'b010, P,  5, 3'b010, 24'hA51234, 3'b010, 3'b000};
      tv[5] = '{3'b100, P, -1, 3'b100, 24'hC0FFEE, 3'b000, 3'b100};
      tv[6] = '{3'b001, P, 16, 3'b001, 24'h0BA11A, 3'b001, 3'b000};
      tv[7] = '{3'b101, P,  2, 3'b100, 24'hC0FFEE, 3'b100, 3'b000};
      tv[8] = '{3'b011, P,  3, 3'b001, 24'h0BA11A, 3'b001, 3'b000};
      tv[9] = '{3'b001, Q,  1, 3'b001, 24'h123456, 3'b001, 3'b000};

      bus.req         = 3'b000;
      bus.req_payload = 72'h0;
      bus.m_done      = 1'b0;
      reset           = 1'b1;
      tick();
      tick();
      chk("rst outs", {bus.grant, bus.done, bus.err, bus.m_start, bus.busy}, 0);
      chk("rst m_data", bus.m_data, 0);
      reset = 1'b0;
      tick();
      chk("post-rst idle", {bus.grant, bus.m_start, bus.busy}, 0);

      for (int i = 0; i < 10; i++) begin
         bus.req_payload = tv[i].pay;
         bus.req         = tv[i].req;
         n     = 0;
         stray = 1'b0;
         do begin
            tick();
            n++;
         end while (bus.grant == 3'b000 && n < 8);
         chk($sformatf("v%0d grant", i), bus.grant, tv[i].g);
         chk($sformatf("v%0d grant lat", i), n, 1);
         chk($sformatf("v%0d start/busy", i), {bus.m_start, bus.busy}, 2'b11);
         chk($sformatf("v%0d m_data", i), bus.m_data, tv[i].d);
         bus.req = bus.req & ~bus.grant;
         if (tv[i].dly >= 0) begin
            for (int k = 0; k < tv[i].dly; k++) begin
               tick();
               if ((bus.grant | bus.done | bus.err) != 3'b000) stray = 1'b1;
            end
            bus.m_done = 1'b1;
            tick();
            bus.m_done = 1'b0;
         end else begin
            n = 0;
            do begin
               tick();
               n++;
               if ((bus.grant | bus.done) != 3'b000) stray = 1'b1;
            end while (bus.err == 3'b000 && n < 40);
            chk($sformatf("v%0d err lat", i), n, TO + 1);
         end
         chk($sformatf("v%0d done", i), bus.done, tv[i].dn);
         chk($sformatf("v%0d err", i), bus.err, tv[i].er);
         chk($sformatf("v%0d busy end", i), bus.busy, 1'b0);
         chk($sformatf("v%0d stray", i), stray, 1'b0);
         bus.req = 3'b000;
         tick();
         chk($sformatf("v%0d pulse width", i), bus.done | bus.err, 3'b000);
         tick();
      end

      // Spurious m_done in IDLE, then a new request during WAIT_DONE.
      bus.req_payload = P;
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      chk("idle m_done", {bus.done, bus.busy}, 0);
      tick();
      chk("idle m_done 2", bus.done, 3'b000);
      bus.req = 3'b001;
      tick();
      chk("iso grant0", bus.grant, 3'b001);
      bus.req = 3'b010;
      stray = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.grant != 3'b000) stray = 1'b1;
      end
      chk("iso no grant busy", stray, 1'b0);
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      chk("iso done0", bus.done, 3'b001);
      chk("iso grant D+1", bus.grant, 3'b000);
      tick();
      chk("iso grant D+2", bus.grant, 3'b000);
      tick();
      chk("iso grant D+3", bus.grant, 3'b010);
      chk("iso m_data1", bus.m_data, 24'hA51234);
      bus.req = 3'b000;
      tick();
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      chk("iso done1", bus.done, 3'b010);
      tick();
      tick();

      // Reset in the middle of WAIT_DONE.
      bus.req = 3'b100;
      tick();
      chk("rst2 grant", bus.grant, 3'b100);
      bus.req = 3'b000;
      tick();
      tick();
      tick();
      chk("rst2 busy before", bus.busy, 1'b1);
      #5 reset = 1'b1;
      #1;
      chk("rst2 outs", {bus.grant, bus.done, bus.err, bus.m_start, bus.busy}, 0);
      chk("rst2 m_data", bus.m_data, 0);
      tick();
      tick();
      chk("rst2 no done/err", bus.done | bus.err, 3'b000);
      reset = 1'b0;
      bus.req = 3'b111;
      tick();
      chk("rst2 first grant", bus.grant, 3'b001);
      bus.req = 3'b000;
      tick();
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      chk("rst2 done", bus.done, 3'b001);
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
